// File: rtl/radix4_bfly_pipe_if.sv
// Beat-level stream interface for the radix-4 butterfly: input handshake with
// four samples, three twiddles and per-beat mode bits, plus the output handshake.
interface radix4_bfly_pipe_if #(
    parameter int DW  = 32,
    parameter int TWW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*DW-1:0]      y0, y1, y2, y3;
    logic [2*TWW-1:0]     tf1, tf2, tf3;
    logic                 inverse;
    logic [1:0]           scale;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*DW-1:0]      x0, x1, x2, x3;
    logic                 ovf;

    modport master (
        output in_valid, y0, y1, y2, y3, tf1, tf2, tf3, inverse, scale, out_ready,
        input  in_ready, out_valid, x0, x1, x2, x3, ovf
    );

    modport slave (
        input  in_valid, y0, y1, y2, y3, tf1, tf2, tf3, inverse, scale, out_ready,
        output in_ready, out_valid, x0, x1, x2, x3, ovf
    );
endinterface

// File: rtl/radix4_bfly_pipe.sv
// Four-stage pipelined radix-4 DIT butterfly with twiddle multiply, rounding,
// selectable output scaling and saturation; one global stall enable.
module radix4_bfly_pipe #(
    parameter int DW  = 32,
    parameter int TWW = 16,
    parameter int TWF = 14
) (
    input logic               clk,
    input logic               nrst,
    radix4_bfly_pipe_if.slave bus
);
    localparam int PW = DW + TWW + 1;
    localparam int OW = DW + 1;
    localparam int UW = DW + 2;
    localparam int ZW = DW + 3;
    localparam logic signed [PW:0] RND = (PW+1)'(1) <<< (TWF - 1);

    logic en;

    logic                  v1_q, v1_d, inv1_q, inv1_d;
    logic [1:0]            scale1_q, scale1_d;
    logic signed [DW-1:0]  yr1_q [4], yr1_d [4], yi1_q [4], yi1_d [4];
    logic signed [TWW-1:0] tr1_q [3], tr1_d [3], ti1_q [3], ti1_d [3];

    logic                  v2_q, v2_d, inv2_q, inv2_d;
    logic [1:0]            scale2_q, scale2_d;
    logic signed [DW-1:0]  y0r2_q, y0r2_d, y0i2_q, y0i2_d;
    logic signed [PW-1:0]  pr2_q [3], pr2_d [3], pi2_q [3], pi2_d [3];

    logic                  v3_q, v3_d, inv3_q, inv3_d;
    logic [1:0]            scale3_q, scale3_d;
    logic signed [DW-1:0]  y0r3_q, y0r3_d, y0i3_q, y0i3_d;
    logic signed [OW-1:0]  or3_q [3], or3_d [3], oi3_q [3], oi3_d [3];

    logic                  out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [2*DW-1:0]       x_q [4], x_d [4];

    logic signed [PW:0]    rnd_r, rnd_i;
    logic signed [UW-1:0]  u0r, u0i, u1r, u1i, v0r, v0i, v1r, v1i;
    logic signed [ZW-1:0]  zr [4], zi [4];
    logic [DW:0]           sr [4], si [4];
    logic                  sat_any;

    // Round-half-up right shift by 0..2 (3 acts as 2), then clamp to DW bits.
    // Bit DW of the result flags that the clamp was applied.
    function automatic logic [DW:0] scale_sat(input logic signed [ZW-1:0] z, input logic [1:0] s);
        logic [1:0]         sh;
        logic signed [ZW:0] t;
        logic [DW:0]        res;
        sh = (s == 2'd3) ? 2'd2 : s;
        t  = (ZW+1)'(z);
        if (sh != 2'd0)
            t = t + ((ZW+1)'(1) <<< (sh - 2'd1));
        t = t >>> sh;
        if ((&t[ZW:DW-1]) || (~|t[ZW:DW-1]))
            res = {1'b0, t[DW-1:0]};
        else if (t[ZW])
            res = {1'b1, 1'b1, {(DW-1){1'b0}}};
        else
            res = {1'b1, 1'b0, {(DW-1){1'b1}}};
        return res;
    endfunction

    assign en            = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.x0        = x_q[0];
    assign bus.x1        = x_q[1];
    assign bus.x2        = x_q[2];
    assign bus.x3        = x_q[3];

    always_comb begin
        v1_d = v1_q;  inv1_d = inv1_q;  scale1_d = scale1_q;
        yr1_d = yr1_q;  yi1_d = yi1_q;  tr1_d = tr1_q;  ti1_d = ti1_q;
        v2_d = v2_q;  inv2_d = inv2_q;  scale2_d = scale2_q;
        y0r2_d = y0r2_q;  y0i2_d = y0i2_q;  pr2_d = pr2_q;  pi2_d = pi2_q;
        v3_d = v3_q;  inv3_d = inv3_q;  scale3_d = scale3_q;
        y0r3_d = y0r3_q;  y0i3_d = y0i3_q;  or3_d = or3_q;  oi3_d = oi3_q;
        rnd_r = '0;
        rnd_i = '0;
        if (en) begin
            v1_d     = bus.in_valid;
            inv1_d   = bus.inverse;
            scale1_d = bus.scale;
            yr1_d[0] = bus.y0[2*DW-1:DW];  yi1_d[0] = bus.y0[DW-1:0];
            yr1_d[1] = bus.y1[2*DW-1:DW];  yi1_d[1] = bus.y1[DW-1:0];
            yr1_d[2] = bus.y2[2*DW-1:DW];  yi1_d[2] = bus.y2[DW-1:0];
            yr1_d[3] = bus.y3[2*DW-1:DW];  yi1_d[3] = bus.y3[DW-1:0];
            tr1_d[0] = bus.tf1[2*TWW-1:TWW];  ti1_d[0] = bus.tf1[TWW-1:0];
            tr1_d[1] = bus.tf2[2*TWW-1:TWW];  ti1_d[1] = bus.tf2[TWW-1:0];
            tr1_d[2] = bus.tf3[2*TWW-1:TWW];  ti1_d[2] = bus.tf3[TWW-1:0];

            v2_d = v1_q;  inv2_d = inv1_q;  scale2_d = scale1_q;
            y0r2_d = yr1_q[0];  y0i2_d = yi1_q[0];
            for (int k = 0; k < 3; k++) begin
                pr2_d[k] = PW'(yr1_q[k+1]) * PW'(tr1_q[k]) - PW'(yi1_q[k+1]) * PW'(ti1_q[k]);
                pi2_d[k] = PW'(yr1_q[k+1]) * PW'(ti1_q[k]) + PW'(yi1_q[k+1]) * PW'(tr1_q[k]);
            end

            v3_d = v2_q;  inv3_d = inv2_q;  scale3_d = scale2_q;
            y0r3_d = y0r2_q;  y0i3_d = y0i2_q;
            for (int k = 0; k < 3; k++) begin
                rnd_r    = (PW+1)'(pr2_q[k]) + RND;
                rnd_i    = (PW+1)'(pi2_q[k]) + RND;
                or3_d[k] = OW'(rnd_r >>> TWF);
                oi3_d[k] = OW'(rnd_i >>> TWF);
            end
        end
    end

    // Final butterfly; the output registers only load on real beats so that
    // bubbles leave the last result visible.
    always_comb begin
        u0r = UW'(y0r3_q) + UW'(or3_q[1]);
        u0i = UW'(y0i3_q) + UW'(oi3_q[1]);
        u1r = UW'(y0r3_q) - UW'(or3_q[1]);
        u1i = UW'(y0i3_q) - UW'(oi3_q[1]);
        v0r = UW'(or3_q[0]) + UW'(or3_q[2]);
        v0i = UW'(oi3_q[0]) + UW'(oi3_q[2]);
        v1r = UW'(or3_q[0]) - UW'(or3_q[2]);
        v1i = UW'(oi3_q[0]) - UW'(oi3_q[2]);

        zr[0] = ZW'(u0r) + ZW'(v0r);
        zi[0] = ZW'(u0i) + ZW'(v0i);
        zr[2] = ZW'(u0r) - ZW'(v0r);
        zi[2] = ZW'(u0i) - ZW'(v0i);
        if (!inv3_q) begin
            zr[1] = ZW'(u1r) + ZW'(v1i);  zi[1] = ZW'(u1i) - ZW'(v1r);
            zr[3] = ZW'(u1r) - ZW'(v1i);  zi[3] = ZW'(u1i) + ZW'(v1r);
        end else begin
            zr[1] = ZW'(u1r) - ZW'(v1i);  zi[1] = ZW'(u1i) + ZW'(v1r);
            zr[3] = ZW'(u1r) + ZW'(v1i);  zi[3] = ZW'(u1i) - ZW'(v1r);
        end

        sat_any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sr[k]   = scale_sat(zr[k], scale3_q);
            si[k]   = scale_sat(zi[k], scale3_q);
            sat_any = sat_any | sr[k][DW] | si[k][DW];
        end

        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        x_d         = x_q;
        if (en) begin
            out_valid_d = v3_q;
            if (v3_q) begin
                ovf_d = sat_any;
                for (int k = 0; k < 4; k++)
                    x_d[k] = {sr[k][DW-1:0], si[k][DW-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1_q <= 1'b0;  inv1_q <= 1'b0;  scale1_q <= '0;
            yr1_q <= '{default: '0};  yi1_q <= '{default: '0};
            tr1_q <= '{default: '0};  ti1_q <= '{default: '0};
            v2_q <= 1'b0;  inv2_q <= 1'b0;  scale2_q <= '0;
            y0r2_q <= '0;  y0i2_q <= '0;
            pr2_q <= '{default: '0};  pi2_q <= '{default: '0};
            v3_q <= 1'b0;  inv3_q <= 1'b0;  scale3_q <= '0;
            y0r3_q <= '0;  y0i3_q <= '0;
            or3_q <= '{default: '0};  oi3_q <= '{default: '0};
            out_valid_q <= 1'b0;  ovf_q <= 1'b0;
            x_q <= '{default: '0};
        end else begin
            v1_q <= v1_d;  inv1_q <= inv1_d;  scale1_q <= scale1_d;
            yr1_q <= yr1_d;  yi1_q <= yi1_d;  tr1_q <= tr1_d;  ti1_q <= ti1_d;
            v2_q <= v2_d;  inv2_q <= inv2_d;  scale2_q <= scale2_d;
            y0r2_q <= y0r2_d;  y0i2_q <= y0i2_d;  pr2_q <= pr2_d;  pi2_q <= pi2_d;
            v3_q <= v3_d;  inv3_q <= inv3_d;  scale3_q <= scale3_d;
            y0r3_q <= y0r3_d;  y0i3_q <= y0i3_d;  or3_q <= or3_d;  oi3_q <= oi3_d;
            out_valid_q <= out_valid_d;  ovf_q <= ovf_d;
            x_q <= x_d;
        end
    end
endmodule

// File: tb/tb_radix4_bfly_pipe.sv
// Directed and streaming bench for radix4_bfly_pipe; expected beats come from a
// 4-point DFT model and are matched in order against the output handshake.
module tb_radix4_bfly_pipe;
    localparam int DW  = 32;
    localparam int TWW = 16;
    localparam int TWF = 14;

    typedef struct packed {
        logic [63:0] y0, y1, y2, y3;
        logic [31:0] tf1, tf2, tf3;
        logic        inverse;
        logic [1:0]  scale;
    } beat_t;

    typedef struct packed {
        logic [63:0] x0, x1, x2, x3;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        nrst;
    int          total = 0;
    int          bad = 0;
    int          out_count = 0;
    int          base_count;
    int          lat;
    exp_t        sb[$];
    exp_t        mon_exp;
    logic [63:0] prev_x0;
    logic        prev_ovf;
    logic        have_prev = 1'b0;

    radix4_bfly_pipe_if #(.DW(DW), .TWW(TWW)) bus ();

    radix4_bfly_pipe #(.DW(DW), .TWW(TWW), .TWF(TWF)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic longint wrapS(input longint v, input int n);
        longint t;
        t = v <<< (64 - n);
        return t >>> (64 - n);
    endfunction

    function automatic longint clampS(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Direct 4-point DFT: x_k = sum_m a_m * w^(m*k), w = -j forward, +j inverse.
    function automatic exp_t model(input beat_t b);
        longint      ar[4], ai[4];
        longint      yr, yi, tr, ti, pr, pi, zr, zi, vr, vi;
        logic [63:0] yk, xk[4];
        logic [31:0] tk;
        logic        ov;
        int          s, p;
        exp_t        e;
        ar[0] = longint'($signed(b.y0[63:32]));
        ai[0] = longint'($signed(b.y0[31:0]));
        for (int k = 1; k < 4; k++) begin
            yk = (k == 1) ? b.y1 : (k == 2) ? b.y2 : b.y3;
            tk = (k == 1) ? b.tf1 : (k == 2) ? b.tf2 : b.tf3;
            yr = longint'($signed(yk[63:32]));
            yi = longint'($signed(yk[31:0]));
            tr = longint'($signed(tk[31:16]));
            ti = longint'($signed(tk[15:0]));
            pr = yr * tr - yi * ti;
            pi = yr * ti + yi * tr;
            ar[k] = wrapS((pr + (longint'(1) <<< (TWF - 1))) >>> TWF, DW + 1);
            ai[k] = wrapS((pi + (longint'(1) <<< (TWF - 1))) >>> TWF, DW + 1);
        end
        s  = (b.scale == 2'd3) ? 2 : int'(b.scale);
        ov = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            zr = 0;
            zi = 0;
            for (int m = 0; m < 4; m++) begin
                p = b.inverse ? ((m * kk) % 4) : ((3 * m * kk) % 4);
                case (p)
                    0: begin zr = zr + ar[m]; zi = zi + ai[m]; end
                    1: begin zr = zr - ai[m]; zi = zi + ar[m]; end
                    2: begin zr = zr - ar[m]; zi = zi - ai[m]; end
                    default: begin zr = zr + ai[m]; zi = zi - ar[m]; end
                endcase
            end
            if (s > 0) begin
                zr = (zr + (longint'(1) <<< (s - 1))) >>> s;
                zi = (zi + (longint'(1) <<< (s - 1))) >>> s;
            end
            vr = clampS(zr);
            vi = clampS(zi);
            if (vr != zr || vi != zi) ov = 1'b1;
            xk[kk] = {vr[31:0], vi[31:0]};
        end
        e.x0  = xk[0];
        e.x1  = xk[1];
        e.x2  = xk[2];
        e.x3  = xk[3];
        e.ovf = ov;
        return e;
    endfunction

    function automatic beat_t curBeat();
        beat_t b;
        b.y0 = bus.y0;  b.y1 = bus.y1;  b.y2 = bus.y2;  b.y3 = bus.y3;
        b.tf1 = bus.tf1;  b.tf2 = bus.tf2;  b.tf3 = bus.tf3;
        b.inverse = bus.inverse;
        b.scale = bus.scale;
        return b;
    endfunction

    function automatic beat_t mkBeat(input logic [63:0] y0, y1, y2, y3,
                                     input logic [31:0] tf1, tf2, tf3,
                                     input logic inv, input logic [1:0] sc);
        beat_t b;
        b.y0 = y0;  b.y1 = y1;  b.y2 = y2;  b.y3 = y3;
        b.tf1 = tf1;  b.tf2 = tf2;  b.tf3 = tf3;
        b.inverse = inv;
        b.scale = sc;
        return b;
    endfunction

    function automatic beat_t randBeat();
        beat_t b;
        b.y0 = {$urandom(), $urandom()};
        b.y1 = {$urandom(), $urandom()};
        b.y2 = {$urandom(), $urandom()};
        b.y3 = {$urandom(), $urandom()};
        b.tf1 = $urandom();
        b.tf2 = $urandom();
        b.tf3 = $urandom();
        b.inverse = 1'($urandom_range(0, 1));
        b.scale = 2'($urandom_range(0, 3));
        return b;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic applyStimulus(input beat_t b);
        logic acc;
        acc = 1'b0;
        bus.y0 = b.y0;  bus.y1 = b.y1;  bus.y2 = b.y2;  bus.y3 = b.y3;
        bus.tf1 = b.tf1;  bus.tf2 = b.tf2;  bus.tf3 = b.tf3;
        bus.inverse = b.inverse;
        bus.scale = b.scale;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    // Leaves the caller at a falling edge with out_valid high (or times out).
    task automatic waitOutput();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        checkOutput("out_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!nrst) begin
            sb.delete();
        end else begin
            checkOutput("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    checkOutput("sb_x0", bus.x0, mon_exp.x0);
                    checkOutput("sb_x1", bus.x1, mon_exp.x1);
                    checkOutput("sb_x2", bus.x2, mon_exp.x2);
                    checkOutput("sb_x3", bus.x3, mon_exp.x3);
                    checkOutput("sb_ovf", 64'(bus.ovf), 64'(mon_exp.ovf));
                    out_count++;
                end
            end else if (!bus.out_valid && have_prev) begin
                checkOutput("hold_x0", bus.x0, prev_x0);
                checkOutput("hold_ovf", 64'(bus.ovf), 64'(prev_ovf));
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(curBeat()));
        end
        prev_x0   = bus.x0;
        prev_ovf  = bus.ovf;
        have_prev = 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nrst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.y0 = '0;  bus.y1 = '0;  bus.y2 = '0;  bus.y3 = '0;
        bus.tf1 = '0;  bus.tf2 = '0;  bus.tf3 = '0;
        bus.inverse = 1'b0;
        bus.scale = 2'd0;
        #2;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_x0", bus.x0, 64'd0);
        checkOutput("rst_ovf", 64'(bus.ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        $display("[TB] unit samples, unity twiddles");
        applyStimulus(mkBeat({32'd1, 32'd0}, {32'd1, 32'd0}, {32'd1, 32'd0}, {32'd1, 32'd0},
                             {16'd16384, 16'd0}, {16'd16384, 16'd0}, {16'd16384, 16'd0}, 1'b0, 2'd0));
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'd4);
        checkOutput("unit_x0", bus.x0, {32'd4, 32'd0});
        checkOutput("unit_x1", bus.x1, 64'd0);
        checkOutput("unit_x2", bus.x2, 64'd0);
        checkOutput("unit_x3", bus.x3, 64'd0);
        checkOutput("unit_ovf", 64'(bus.ovf), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] twiddle j on y1, forward then inverse");
        applyStimulus(mkBeat(64'd0, {32'd100, 32'd0}, 64'd0, 64'd0,
                             {16'd0, 16'd16384}, 32'd0, 32'd0, 1'b0, 2'd0));
        waitOutput();
        checkOutput("fwd_x0", bus.x0, {32'd0, 32'd100});
        checkOutput("fwd_x1", bus.x1, {32'd100, 32'd0});
        checkOutput("fwd_x2", bus.x2, {32'd0, 32'hFFFF_FF9C});
        checkOutput("fwd_x3", bus.x3, {32'hFFFF_FF9C, 32'd0});
        @(posedge clk);
        #1;
        applyStimulus(mkBeat(64'd0, {32'd100, 32'd0}, 64'd0, 64'd0,
                             {16'd0, 16'd16384}, 32'd0, 32'd0, 1'b1, 2'd0));
        waitOutput();
        checkOutput("inv_x1", bus.x1, {32'hFFFF_FF9C, 32'd0});
        checkOutput("inv_x3", bus.x3, {32'd100, 32'd0});
        @(posedge clk);
        #1;

        $display("[TB] positive full-scale sum, scale 0 then 1");
        applyStimulus(mkBeat({32'h7FFF_FFFF, 32'd0}, 64'd0, {32'h7FFF_FFFF, 32'd0}, 64'd0,
                             32'd0, {16'd16384, 16'd0}, 32'd0, 1'b0, 2'd0));
        waitOutput();
        checkOutput("sat0_x0", bus.x0, {32'h7FFF_FFFF, 32'd0});
        checkOutput("sat0_ovf", 64'(bus.ovf), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(mkBeat({32'h7FFF_FFFF, 32'd0}, 64'd0, {32'h7FFF_FFFF, 32'd0}, 64'd0,
                             32'd0, {16'd16384, 16'd0}, 32'd0, 1'b0, 2'd1));
        waitOutput();
        checkOutput("sat1_x0", bus.x0, {32'h7FFF_FFFF, 32'd0});
        checkOutput("sat1_ovf", 64'(bus.ovf), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] rounding with scale 2");
        applyStimulus(mkBeat({32'd6, 32'hFFFF_FFFA}, 64'd0, 64'd0, 64'd0,
                             32'd0, 32'd0, 32'd0, 1'b0, 2'd2));
        waitOutput();
        checkOutput("rnd_x0", bus.x0, {32'd2, 32'hFFFF_FFFF});
        checkOutput("rnd_x2", bus.x2, {32'd2, 32'hFFFF_FFFF});
        @(posedge clk);
        #1;

        $display("[TB] eight back-to-back random beats with a 3-cycle stall");
        base_count = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(randBeat());
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        checkOutput("stream_count", 64'(out_count - base_count), 64'd8);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] reset with three beats in flight");
        for (int i = 0; i < 3; i++) applyStimulus(randBeat());
        nrst = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_x0", bus.x0, 64'd0);
        checkOutput("mid_rst_x1", bus.x1, 64'd0);
        checkOutput("mid_rst_x2", bus.x2, 64'd0);
        checkOutput("mid_rst_x3", bus.x3, 64'd0);
        checkOutput("mid_rst_ovf", 64'(bus.ovf), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 nrst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("post_rst_quiet", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        applyStimulus(mkBeat({32'd1, 32'd0}, {32'd1, 32'd0}, {32'd1, 32'd0}, {32'd1, 32'd0},
                             {16'd16384, 16'd0}, {16'd16384, 16'd0}, {16'd16384, 16'd0}, 1'b0, 2'd0));
        waitOutput();
        checkOutput("post_rst_x0", bus.x0, {32'd4, 32'd0});
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
